// File: rtl/lwb_pkg.sv
// Shared types and helpers for line_window_buffer: FSM state encoding,
// default dimension width, and the per-frame window count formula.
package lwb_pkg;

    localparam int unsigned LWB_DIM_W = 13;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } lwb_state_e;

    // Windows produced for a frame whose dimensions are given as (size - 1).
    function automatic int unsigned win_count(input int unsigned w_m1,
                                              input int unsigned h_m1,
                                              input int unsigned win);
        return (h_m1 + 2 - win) * (w_m1 + 2 - win);
    endfunction

endpackage

// File: rtl/line_store.sv
// One line of pixel history: combinational read and synchronous write
// sharing a single address. Contents are never cleared.
module line_store
    import lwb_pkg::*;
#(
    parameter int unsigned PIX_W     = 32,
    parameter int unsigned MAX_WIDTH = 1024,
    parameter int unsigned AW        = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [PIX_W-1:0] wdata,
    output logic [PIX_W-1:0] rdata
);

    logic [PIX_W-1:0] mem_q [MAX_WIDTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[addr] <= wdata;
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/line_window_buffer.sv
// Streaming WIN x WIN window generator over raster-order pixels using WIN-1 line stores.
// Define LWB_PERF_CNT_EN to build the output stall counter (stall_cycles); otherwise it reads 0.
module line_window_buffer
    import lwb_pkg::*;
#(
    parameter int unsigned PIX_W     = 32,
    parameter int unsigned WIN       = 3,
    parameter int unsigned MAX_WIDTH = 1024,
    parameter int unsigned DIM_W     = LWB_DIM_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [DIM_W-1:0]         img_width,
    input  logic [DIM_W-1:0]         img_height,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PIX_W-1:0]         in_pixel,
    output logic                     win_valid,
    input  logic                     win_ready,
    output logic [WIN*WIN*PIX_W-1:0] win_data,
    output logic                     busy,
    output logic                     done,
    output logic                     cfg_err,
    output logic [31:0]              stall_cycles
);

    localparam int unsigned AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    localparam int unsigned NL = WIN - 1;
    localparam logic [DIM_W:0]   WIN_EXT = (DIM_W + 1)'(WIN);
    localparam logic [DIM_W:0]   MAX_EXT = (DIM_W + 1)'(MAX_WIDTH);
    localparam logic [DIM_W-1:0] WIN_M1  = DIM_W'(WIN - 1);

    lwb_state_e               state_q, state_d;
    logic [DIM_W-1:0]         width_q, width_d, height_q, height_d;
    logic [DIM_W-1:0]         col_q, col_d, row_q, row_d;
    logic                     win_valid_q, win_valid_d;
    logic [WIN*WIN*PIX_W-1:0] win_data_q, win_data_d;
    logic                     cfg_err_q, cfg_err_d;

    logic [NL-1:0][PIX_W-1:0]  line_rd, line_wd;
    logic [WIN-1:0][PIX_W-1:0] col_vec;
    logic [DIM_W:0]            w_ext, h_ext;
    logic                      dims_ok, in_ready_c, accept;

    assign w_ext      = {1'b0, img_width} + (DIM_W + 1)'(1);
    assign h_ext      = {1'b0, img_height} + (DIM_W + 1)'(1);
    assign dims_ok    = (w_ext >= WIN_EXT) && (w_ext <= MAX_EXT) && (h_ext >= WIN_EXT);
    assign in_ready_c = (state_q == RUN) && !(win_valid_q && !win_ready);
    assign accept     = in_valid && in_ready_c;

    // Column vector runs oldest line (r=0) to the incoming pixel (r=WIN-1).
    always_comb begin
        line_wd         = '0;
        col_vec         = '0;
        line_wd[0]      = in_pixel;
        col_vec[WIN-1]  = in_pixel;
        for (int unsigned k = 1; k < NL; k++) line_wd[k] = line_rd[k-1];
        for (int unsigned k = 0; k < NL; k++) col_vec[NL-1-k] = line_rd[k];
    end

    for (genvar k = 0; k < NL; k++) begin : g_line
        line_store #(
            .PIX_W    (PIX_W),
            .MAX_WIDTH(MAX_WIDTH),
            .AW       (AW)
        ) u_store (
            .clk  (clk),
            .we   (accept),
            .addr (col_q[AW-1:0]),
            .wdata(line_wd[k]),
            .rdata(line_rd[k])
        );
    end

    always_comb begin
        state_d     = state_q;
        width_d     = width_q;
        height_d    = height_q;
        col_d       = col_q;
        row_d       = row_q;
        win_valid_d = win_valid_q;
        win_data_d  = win_data_q;
        cfg_err_d   = 1'b0;

        if (win_valid_q && win_ready) win_valid_d = 1'b0;

        // The window shifts on every accept; only full in-image positions raise valid.
        if (accept) begin
            for (int unsigned r = 0; r < WIN; r++) begin
                for (int unsigned c = 0; c + 1 < WIN; c++)
                    win_data_d[(r*WIN+c)*PIX_W +: PIX_W] = win_data_q[(r*WIN+c+1)*PIX_W +: PIX_W];
                win_data_d[(r*WIN+WIN-1)*PIX_W +: PIX_W] = col_vec[r];
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (dims_ok) begin
                        width_d  = img_width;
                        height_d = img_height;
                        col_d    = '0;
                        row_d    = '0;
                        state_d  = RUN;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    if (row_q >= WIN_M1 && col_q >= WIN_M1) win_valid_d = 1'b1;
                    if (col_q == width_q) begin
                        col_d = '0;
                        if (row_q == height_q) state_d = DRAIN;
                        else row_d = row_q + DIM_W'(1);
                    end else begin
                        col_d = col_q + DIM_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (!win_valid_q || win_ready) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            width_q     <= '0;
            height_q    <= '0;
            col_q       <= '0;
            row_q       <= '0;
            win_valid_q <= 1'b0;
            win_data_q  <= '0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            width_q     <= width_d;
            height_q    <= height_d;
            col_q       <= col_d;
            row_q       <= row_d;
            win_valid_q <= win_valid_d;
            win_data_q  <= win_data_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

`ifdef LWB_PERF_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == IDLE && start && dims_ok) stall_d = '0;
        else if (win_valid_q && !win_ready && stall_q != '1) stall_d = stall_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) stall_q <= '0;
        else     stall_q <= stall_d;
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

    assign in_ready  = in_ready_c;
    assign win_valid = win_valid_q;
    assign win_data  = win_data_q;
    assign busy      = (state_q == RUN) || (state_q == DRAIN);
    assign done      = (state_q == DONE);
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_line_window_buffer.sv
// Directed bench for line_window_buffer: a WIN=3 instance and a WIN=5/MAX_WIDTH=16 instance.
module tb_line_window_buffer;
    import lwb_pkg::*;

    localparam int A_WIN = 3;
    localparam int A_PW  = 32;
    localparam int B_WIN = 5;
    localparam int B_PW  = 16;
    localparam int B_MAX = 16;
    localparam int DW    = 13;
    localparam int A_VW  = A_WIN * A_WIN * A_PW;
    localparam int B_VW  = B_WIN * B_WIN * B_PW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic            a_start = 1'b0, a_in_valid = 1'b0, a_win_ready = 1'b0;
    logic [DW-1:0]   a_w = '0, a_h = '0;
    logic [A_PW-1:0] a_in_pixel = '0;
    logic            a_in_ready, a_win_valid, a_busy, a_done, a_cfg_err;
    logic [A_VW-1:0] a_win_data;
    logic [31:0]     a_stall;

    logic            b_start = 1'b0, b_in_valid = 1'b0, b_win_ready = 1'b0;
    logic [DW-1:0]   b_w = '0, b_h = '0;
    logic [B_PW-1:0] b_in_pixel = '0;
    logic            b_in_ready, b_win_valid, b_busy, b_done, b_cfg_err;
    logic [B_VW-1:0] b_win_data;
    logic [31:0]     b_stall;

    int tests_run = 0;
    int tests_failed = 0;

    line_window_buffer #(.PIX_W(A_PW), .WIN(A_WIN), .MAX_WIDTH(1024), .DIM_W(DW)) u_a (
        .clk(clk), .rst(rst), .start(a_start), .img_width(a_w), .img_height(a_h),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_pixel(a_in_pixel),
        .win_valid(a_win_valid), .win_ready(a_win_ready), .win_data(a_win_data),
        .busy(a_busy), .done(a_done), .cfg_err(a_cfg_err), .stall_cycles(a_stall)
    );

    line_window_buffer #(.PIX_W(B_PW), .WIN(B_WIN), .MAX_WIDTH(B_MAX), .DIM_W(DW)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .img_width(b_w), .img_height(b_h),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_pixel(b_in_pixel),
        .win_valid(b_win_valid), .win_ready(b_win_ready), .win_data(b_win_data),
        .busy(b_busy), .done(b_done), .cfg_err(b_cfg_err), .stall_cycles(b_stall)
    );

    // Drives one frame on instance A (pixel = row*16+col) and checks every consumed window.
    task automatic a_frame(input int w, input int h, input bit stall_mode, input int stop_after,
                           input bit poke, output int n_win, output int n_stall, output int n_viol,
                           output int first_acc, output logic [A_VW-1:0] first_win, output int n_done);
        int pr, pc, er, ec, acc, cyc;
        logic [A_VW-1:0] ev;
        pr = 0; pc = 0; er = A_WIN - 1; ec = A_WIN - 1; acc = 0; cyc = 0;
        n_win = 0; n_stall = 0; n_viol = 0; first_acc = -1; first_win = '0; n_done = 0;
        @(negedge clk);
        a_w = DW'(w); a_h = DW'(h); a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        while (n_done == 0 && cyc < 2000) begin
            a_in_valid  = (pr <= h);
            a_in_pixel  = A_PW'(pr * 16 + pc);
            a_win_ready = stall_mode ? (cyc % 3 == 2) : 1'b1;
            a_start     = poke && (cyc == 5);
            if (poke && cyc == 5) begin a_w = DW'(7); a_h = DW'(7); end
            #1;
            if (a_win_valid && first_acc < 0) first_acc = acc;
            if (a_win_valid && !a_win_ready) begin
                n_stall++;
                if (a_in_ready) n_viol++;
            end
            if (a_win_valid && a_win_ready) begin
                for (int i = 0; i < A_WIN; i++)
                    for (int j = 0; j < A_WIN; j++)
                        ev[(i*A_WIN+j)*A_PW +: A_PW] = A_PW'((er - A_WIN + 1 + i) * 16 + ec - A_WIN + 1 + j);
                if (n_win == 0) first_win = a_win_data;
                tests_run++;
                if (a_win_data !== ev) begin
                    tests_failed++;
                    $display("FAIL a_window[%0d] got %h expected %h", n_win, a_win_data, ev);
                end
                n_win++;
                if (ec == w) begin ec = A_WIN - 1; er++; end else ec++;
            end
            if (a_done) n_done++;
            if (a_in_valid && a_in_ready) begin
                acc++;
                if (pc == w) begin pc = 0; pr++; end else pc++;
            end
            cyc++;
            @(negedge clk);
            if (stop_after > 0 && acc >= stop_after) break;
        end
        a_in_valid = 1'b0;
        a_start    = 1'b0;
    endtask

    task automatic b_frame(input int w, input int h, output int n_win,
                           output logic [B_VW-1:0] last_win, output int n_done);
        int pr, pc, er, ec, cyc;
        logic [B_VW-1:0] ev;
        pr = 0; pc = 0; er = B_WIN - 1; ec = B_WIN - 1; cyc = 0;
        n_win = 0; last_win = '0; n_done = 0;
        @(negedge clk);
        b_w = DW'(w); b_h = DW'(h); b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        while (n_done == 0 && cyc < 2000) begin
            b_in_valid  = (pr <= h);
            b_in_pixel  = B_PW'(pr * 16 + pc);
            b_win_ready = 1'b1;
            #1;
            if (b_win_valid) begin
                for (int i = 0; i < B_WIN; i++)
                    for (int j = 0; j < B_WIN; j++)
                        ev[(i*B_WIN+j)*B_PW +: B_PW] = B_PW'((er - B_WIN + 1 + i) * 16 + ec - B_WIN + 1 + j);
                last_win = b_win_data;
                tests_run++;
                if (b_win_data !== ev) begin
                    tests_failed++;
                    $display("FAIL b_window[%0d] got %h expected %h", n_win, b_win_data, ev);
                end
                n_win++;
                if (ec == w) begin ec = B_WIN - 1; er++; end else ec++;
            end
            if (b_done) n_done++;
            if (b_in_valid && b_in_ready) begin
                if (pc == w) begin pc = 0; pr++; end else pc++;
            end
            cyc++;
            @(negedge clk);
        end
        b_in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if ({a_in_ready, a_win_valid, a_busy, a_done, a_cfg_err} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl got %b expected 00000",
                     {a_in_ready, a_win_valid, a_busy, a_done, a_cfg_err});
        end
        tests_run++;
        if (a_win_data !== '0) begin
            tests_failed++; $display("FAIL reset_win_data got %h expected 0", a_win_data);
        end
        tests_run++;
        if (a_stall !== 32'd0) begin
            tests_failed++; $display("FAIL reset_stall got %0d expected 0", a_stall);
        end
        tests_run++;
        if ({b_in_ready, b_win_valid, b_busy} !== 3'b0) begin
            tests_failed++; $display("FAIL reset_b got %b expected 000", {b_in_ready, b_win_valid, b_busy});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int n_win, n_stall, n_viol, first_acc, n_done;
        logic [A_VW-1:0] first_win, first_exp;
        first_exp = {32'h22, 32'h21, 32'h20, 32'h12, 32'h11, 32'h10, 32'h02, 32'h01, 32'h00};
        a_frame(3, 3, 1'b0, 0, 1'b0, n_win, n_stall, n_viol, first_acc, first_win, n_done);
        tests_run++;
        if (n_win != int'(win_count(3, 3, A_WIN))) begin
            tests_failed++; $display("FAIL basic_count got %0d expected 4", n_win);
        end
        tests_run++;
        if (first_win !== first_exp) begin
            tests_failed++; $display("FAIL basic_first_window got %h expected %h", first_win, first_exp);
        end
        tests_run++;
        if (first_acc != 11) begin
            tests_failed++; $display("FAIL basic_latency got %0d pixels expected 11", first_acc);
        end
        tests_run++;
        if (n_done != 1) begin
            tests_failed++; $display("FAIL basic_done got %0d expected 1", n_done);
        end
        #1;
        tests_run++;
        if ({a_done, a_busy} !== 2'b00) begin
            tests_failed++; $display("FAIL basic_done_pulse got %b expected 00", {a_done, a_busy});
        end
    endtask

    task automatic test_backpressure();
        int n_win, n_stall, n_viol, first_acc, n_done, exp_stall;
        logic [A_VW-1:0] first_win;
        a_frame(3, 3, 1'b1, 0, 1'b0, n_win, n_stall, n_viol, first_acc, first_win, n_done);
        tests_run++;
        if (n_win != 4 || n_done != 1) begin
            tests_failed++; $display("FAIL bp_count got %0d windows %0d done expected 4 1", n_win, n_done);
        end
        tests_run++;
        if (n_viol != 0) begin
            tests_failed++; $display("FAIL bp_in_ready got %0d ready-while-pending cycles expected 0", n_viol);
        end
`ifdef LWB_PERF_CNT_EN
        exp_stall = n_stall;
`else
        exp_stall = 0;
`endif
        tests_run++;
        if (a_stall !== 32'(exp_stall)) begin
            tests_failed++; $display("FAIL bp_stall_cycles got %0d expected %0d", a_stall, exp_stall);
        end
    endtask

    task automatic test_cfg_err();
        int ws[3];
        int hs[3];
        ws = '{1, 1024, 3};
        hs = '{3, 3, 1};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            a_w = DW'(ws[k]); a_h = DW'(hs[k]); a_start = 1'b1; a_in_valid = 1'b1;
            @(negedge clk);
            a_start = 1'b0;
            #1;
            tests_run++;
            if ({a_cfg_err, a_busy, a_in_ready} !== 3'b100) begin
                tests_failed++;
                $display("FAIL cfg_err_pulse[%0d] got %b expected 100", k, {a_cfg_err, a_busy, a_in_ready});
            end
            @(negedge clk);
            #1;
            tests_run++;
            if ({a_cfg_err, a_busy, a_in_ready} !== 3'b000) begin
                tests_failed++;
                $display("FAIL cfg_err_clear[%0d] got %b expected 000", k, {a_cfg_err, a_busy, a_in_ready});
            end
            a_in_valid = 1'b0;
        end
        @(negedge clk);
        b_w = DW'(B_MAX); b_h = DW'(5); b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        #1;
        tests_run++;
        if ({b_cfg_err, b_busy} !== 2'b10) begin
            tests_failed++; $display("FAIL cfg_err_b got %b expected 10", {b_cfg_err, b_busy});
        end
    endtask

    task automatic test_win5();
        int n_win, n_done;
        logic [B_VW-1:0] last_win;
        b_frame(15, 5, n_win, last_win, n_done);
        tests_run++;
        if (n_win != 24 || n_done != 1) begin
            tests_failed++; $display("FAIL win5_count got %0d windows %0d done expected 24 1", n_win, n_done);
        end
        tests_run++;
        if (last_win[24*B_PW +: B_PW] !== 16'h005F) begin
            tests_failed++; $display("FAIL win5_last got %h expected 005f", last_win[24*B_PW +: B_PW]);
        end
    endtask

    task automatic test_mid_reset();
        int n_win, n_stall, n_viol, first_acc, n_done;
        logic [A_VW-1:0] first_win;
        a_frame(3, 3, 1'b0, 11, 1'b0, n_win, n_stall, n_viol, first_acc, first_win, n_done);
        a_win_ready = 1'b0;
        #1;
        tests_run++;
        if (a_win_valid !== 1'b1) begin
            tests_failed++; $display("FAIL rst_pending got %b expected 1", a_win_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        tests_run++;
        if ({a_win_valid, a_busy} !== 2'b00) begin
            tests_failed++; $display("FAIL rst_mid got %b expected 00", {a_win_valid, a_busy});
        end
        rst = 1'b0;
        a_frame(3, 3, 1'b0, 0, 1'b0, n_win, n_stall, n_viol, first_acc, first_win, n_done);
        tests_run++;
        if (n_win != 4 || n_done != 1) begin
            tests_failed++; $display("FAIL rst_refill got %0d windows %0d done expected 4 1", n_win, n_done);
        end
    endtask

    task automatic test_start_ignored();
        int n_win, n_stall, n_viol, first_acc, n_done;
        logic [A_VW-1:0] first_win;
        a_frame(3, 3, 1'b0, 0, 1'b1, n_win, n_stall, n_viol, first_acc, first_win, n_done);
        tests_run++;
        if (n_win != 4 || n_done != 1) begin
            tests_failed++; $display("FAIL start_ignored got %0d windows %0d done expected 4 1", n_win, n_done);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_cfg_err();
        test_win5();
        test_mid_reset();
        test_start_ignored();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
